// File: rtl/key_step_sampler.sv
// key_step_sampler: synchronize and debounce an active-low pushbutton, emit one step per press and capture w.
module key_step_sampler #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       key_n,
  input  logic       w_in,
  output logic       step,
  output logic       w_out,
  output logic [7:0] step_count,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    S_IDLE         = 2'b00,
    S_PRESS_WAIT   = 2'b01,
    S_PRESSED      = 2'b10,
    S_RELEASE_WAIT = 2'b11
  } state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic             key_m_q, key_s_q, w_m_q, w_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             w_out_q, w_out_d;
  logic [7:0]       step_count_q, step_count_d;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = 1'b0;
    w_out_d      = w_out_q;
    step_count_d = step_count_q;
    case (state_q)
      S_IDLE: if (!key_s_q) begin
        state_d = S_PRESS_WAIT;
        cnt_d   = '0;
      end
      S_PRESS_WAIT: if (key_s_q) state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) begin
          state_d      = S_PRESSED;
          step_d       = 1'b1;
          w_out_d      = w_s_q;
          step_count_d = step_count_q + 8'd1;
        end else cnt_d = cnt_q + CNT_W'(1);
      S_PRESSED: if (key_s_q) begin
        state_d = S_RELEASE_WAIT;
        cnt_d   = '0;
      end
      S_RELEASE_WAIT: if (!key_s_q) state_d = S_PRESSED;
        else if (cnt_q == CNT_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = S_IDLE;
    endcase
  end
  // Reset parks in S_RELEASE_WAIT so a full released interval is required before arming.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      key_m_q      <= 1'b1;
      key_s_q      <= 1'b1;
      w_m_q        <= 1'b0;
      w_s_q        <= 1'b0;
      state_q      <= S_RELEASE_WAIT;
      cnt_q        <= '0;
      step_q       <= 1'b0;
      w_out_q      <= 1'b0;
      step_count_q <= 8'd0;
    end else begin
      key_m_q      <= key_n;
      key_s_q      <= key_m_q;
      w_m_q        <= w_in;
      w_s_q        <= w_m_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      w_out_q      <= w_out_d;
      step_count_q <= step_count_d;
    end
  end
  assign step       = step_q;
  assign w_out      = w_out_q;
  assign step_count = step_count_q;
  assign state      = state_q;
endmodule

// File: tb/tb_key_step_sampler.sv
// tb_key_step_sampler: directed and random checks of key_step_sampler against a run-length press model.
module tb_key_step_sampler;
  localparam int D = 4;
  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       key_n = 1'b1;
  logic       w_in = 1'b0;
  logic       step, w_out;
  logic [7:0] step_count;
  logic [1:0] state;
  int total = 0;
  int bad = 0;
  int dut_pulses = 0;
  // Model: a press is accepted once the synchronized key has been low for D+1 edges while armed;
  // arming needs D+1 edges of high key (the reset edge counts as the first).
  logic       m_k1 = 1'b1, m_k2 = 1'b1, m_w1 = 1'b0, m_w2 = 1'b0;
  logic       m_armed = 1'b0, m_step = 1'b0, m_wout = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  int         m_lo = 0, m_hi = 1;

  key_step_sampler #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .key_n(key_n), .w_in(w_in),
    .step(step), .w_out(w_out), .step_count(step_count), .state(state)
  );

  always #5 Clock = ~Clock;

  function automatic logic [1:0] m_state();
    return m_armed ? (m_lo == 0 ? 2'b00 : 2'b01) : (m_hi == 0 ? 2'b10 : 2'b11);
  endfunction

  function automatic logic [11:0] m_vec();
    return {m_step, m_wout, m_cnt, m_state()};
  endfunction

  task automatic tick();
    @(posedge Clock);
    if (!Resetn) begin
      m_k1 = 1'b1; m_k2 = 1'b1; m_w1 = 1'b0; m_w2 = 1'b0;
      m_armed = 1'b0; m_step = 1'b0; m_wout = 1'b0; m_cnt = 8'd0;
      m_lo = 0; m_hi = 1;
    end else begin
      m_step = 1'b0;
      if (m_k2) begin m_hi++; m_lo = 0; end else begin m_lo++; m_hi = 0; end
      if (m_armed && m_lo == D + 1) begin
        m_armed = 1'b0; m_step = 1'b1; m_wout = m_w2; m_cnt++;
      end else if (!m_armed && m_hi == D + 1) m_armed = 1'b1;
      m_k2 = m_k1; m_k1 = key_n; m_w2 = m_w1; m_w1 = w_in;
    end
    #1;
    if (step === 1'b1) dut_pulses++;
  endtask

  task automatic test_reset();
    key_n = 1'b1; w_in = 1'b0; Resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({step, w_out, step_count, state} !== 12'h003) begin
        bad++; $display("FAIL reset_vals cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, 12'h003);
      end
    end
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({step, w_out, step_count, state} !== m_vec()) begin
        bad++; $display("FAIL reset_arm cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, m_vec());
      end
    end
    total++;
    if (state !== 2'b00) begin
      bad++; $display("FAIL reset_idle got=%b exp=00", state);
    end
  endtask

  task automatic test_press();
    w_in = 1'b1; key_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({step, w_out, step_count, state} !== m_vec()) begin
        bad++; $display("FAIL press_model cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, m_vec());
      end
      total++;
      if (step !== (i == D + 2)) begin
        bad++; $display("FAIL press_latency cyc=%0d step=%b exp=%b", i, step, i == D + 2);
      end
    end
    total++;
    if ({w_out, step_count, state} !== {1'b1, 8'd1, 2'b10}) begin
      bad++; $display("FAIL press_final got=%h exp=%h", {w_out, step_count, state}, {1'b1, 8'd1, 2'b10});
    end
  endtask

  task automatic test_release_bounce();
    logic pat[11] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int p0 = dut_pulses;
    for (int i = 0; i < 11; i++) begin
      key_n = pat[i];
      tick();
      total++;
      if ({step, w_out, step_count, state} !== m_vec()) begin
        bad++; $display("FAIL relbounce_model cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, m_vec());
      end
    end
    total++;
    if (dut_pulses != p0) begin
      bad++; $display("FAIL relbounce_nostep pulses=%0d exp=%0d", dut_pulses - p0, 0);
    end
    w_in = 1'b0; key_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({step, w_out, step_count, state} !== m_vec()) begin
        bad++; $display("FAIL relbounce_press cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, m_vec());
      end
    end
    total++;
    if ({w_out, step_count, dut_pulses - p0} !== {1'b0, 8'd2, 32'd1}) begin
      bad++; $display("FAIL relbounce_final w_out=%b count=%0d pulses=%0d exp 0/2/1", w_out, step_count, dut_pulses - p0);
    end
    key_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_bounce();
    logic pat[18] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int p0 = dut_pulses;
    w_in = 1'($urandom);
    for (int i = 0; i < 18; i++) begin
      key_n = pat[i];
      tick();
      total++;
      if ({step, w_out, step_count, state} !== m_vec()) begin
        bad++; $display("FAIL bounce_model cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, m_vec());
      end
      total++;
      if (step !== (i == 12)) begin
        bad++; $display("FAIL bounce_timing cyc=%0d step=%b exp=%b", i, step, i == 12);
      end
    end
    total++;
    if (dut_pulses - p0 != 1) begin
      bad++; $display("FAIL bounce_count pulses=%0d exp=1", dut_pulses - p0);
    end
    key_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    int p0 = dut_pulses;
    key_n = 1'b0;
    repeat (5) tick();
    total++;
    if (state !== 2'b01) begin
      bad++; $display("FAIL midrst_prewait got=%b exp=01", state);
    end
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    total++;
    if ({step, w_out, step_count, state} !== 12'h003) begin
      bad++; $display("FAIL midrst_cleared got=%h exp=%h", {step, w_out, step_count, state}, 12'h003);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if ({step, w_out, step_count, state} !== m_vec()) begin
        bad++; $display("FAIL midrst_held cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, m_vec());
      end
    end
    total++;
    if (dut_pulses != p0) begin
      bad++; $display("FAIL midrst_nostep pulses=%0d exp=0", dut_pulses - p0);
    end
    key_n = 1'b1;
    repeat (8) tick();
    key_n = 1'b0;
    repeat (10) tick();
    total++;
    if (dut_pulses - p0 != 1 || step_count !== 8'd1) begin
      bad++; $display("FAIL midrst_fresh pulses=%0d count=%0d exp 1/1", dut_pulses - p0, step_count);
    end
    key_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_wrap();
    int p0;
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    key_n = 1'b1;
    repeat (8) tick();
    p0 = dut_pulses;
    for (int n = 0; n < 257; n++) begin
      w_in = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        key_n = (i >= 8);
        tick();
        total++;
        if ({step, w_out, step_count, state} !== m_vec()) begin
          bad++; $display("FAIL wrap_model press=%0d cyc=%0d got=%h exp=%h", n, i, {step, w_out, step_count, state}, m_vec());
        end
      end
      if (n == 255) begin
        total++;
        if (step_count !== 8'd0 || dut_pulses - p0 != 256) begin
          bad++; $display("FAIL wrap_zero count=%0d pulses=%0d exp 0/256", step_count, dut_pulses - p0);
        end
      end
    end
    total++;
    if (step_count !== 8'd1 || dut_pulses - p0 != 257) begin
      bad++; $display("FAIL wrap_257 count=%0d pulses=%0d exp 1/257", step_count, dut_pulses - p0);
    end
  endtask

  task automatic test_random();
    int run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        key_n = 1'($urandom);
        run = $urandom_range(1, 9);
      end
      run--;
      if ($urandom_range(0, 7) == 0) w_in = 1'($urandom);
      Resetn = ($urandom_range(0, 299) != 0);
      tick();
      total++;
      if ({step, w_out, step_count, state} !== m_vec()) begin
        bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, {step, w_out, step_count, state}, m_vec());
      end
    end
    Resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_press();
    test_release_bounce();
    test_bounce();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
